xregf_mp: RTL and testbench
===========================

Name: xregf_mp

Overview:
Parametrised dual-interface register file for the versat datapath with one host (ext) write/read port and one versat (int) write port. It also provides N_RD independent int read ports. All reads are registered with optional write-to-read forwarding. A host/versat write collision queues the versat write in a one-entry pending buffer instead of dropping it. After reset, a clear sequencer zeroes every entry before the file accepts traffic.

Parameters:
DATA_W, 32, data word width
ADDR_W, 4, address width; depth = 2**ADDR_W
N_RD, 2, number of int read ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the pre-write value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ext_we  in  1  host write enable
ext_addr  in  ADDR_W  host read/write address
ext_data_in  in  DATA_W  host write data
ext_data_out  out  DATA_W  host read data, registered
ext_ready  out  1  file accepting host writes
int_sel  in  1  versat select
int_we  in  1  versat write enable (effective only with int_sel)
int_addr  in  ADDR_W  versat write address
int_data_in  in  DATA_W  versat write data
int_ready  out  1  versat write accepted this cycle
int_rd_addr  in  N_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
int_rd_data  out  N_RD*DATA_W  packed registered read data
clr_busy  out  1  clear sequence in progress
collision  out  1  one-cycle pulse: host and versat wrote in the same cycle

Behaviour:
- rst=1 for one cycle:
  - state <- CLEAR, clear counter <- 0, pending buffer emptied.
  - ext_data_out, int_rd_data, collision <- 0.
  - clr_busy <- 1; ext_ready, int_ready <- 0.
- CLEAR state:
  - Writes 0 to entry [counter] each cycle, counter += 1.
  - After entry 2**ADDR_W-1 is written, move to RUN on the next edge.
  - CLEAR takes exactly 2**ADDR_W cycles; clr_busy drops in the first RUN cycle.
  - Host and versat writes during CLEAR are ignored; no collision pulse.
  - Reads during CLEAR return the current array contents, which are partially cleared.
- RUN state: ext_ready=1 always; int_ready = !pending_valid.
- Write arbitration, per cycle in RUN (vw = int_sel & int_we & int_ready):
  - ext_we only: host write commits at the edge.
  - vw only, pending empty: versat write commits at the edge.
  - ext_we and vw together: host write commits; versat {addr,data} captured into pending; collision=1 the next cycle. This applies for the same or different addresses.
  - pending valid and ext_we=0: pending commits; pending clears.
  - pending valid and ext_we=1: host commits; pending holds.
  - While int_ready=0, the versat master holds its request. An int write with int_ready=0 is not captured.
  - Ordering on a same-address collision: host value written first, versat value overwrites it later. Final value = versat data.
- Reads: 1-cycle latency.
  - ext_data_out <- array[ext_addr]; int_rd_data[k] <- array[int_rd_addr[k]].
  - BYPASS=1: if the address equals the address being committed this cycle (any source), that write data is returned.
  - BYPASS=0: the old array value is returned.
- Only one array write commits per cycle. Storage: one array per read consumer (N_RD+1 copies) or a flop array; all copies stay identical.
- rst asserted mid-RUN, including with pending valid: pending is discarded, clear restarts from 0, and all contents are zeroed again.

Test Plan:
- Reset, ADDR_W=4: rst 1 cycle -> clr_busy=1 for 16 cycles, then 0; all 16 entries read 0; ext_ready 0->1 together with clr_busy falling.
- Write during CLEAR: ext_we addr 3 data 0xAA at clear cycle 2 -> entry 3 reads 0 after clear; collision stays 0.
- Host write/read: ext write addr 5 = 0x12345678, then int_rd_addr[0]=5 and ext_addr=5 -> both outputs = 0x12345678 one cycle after the address is presented.
- Collision, same address: ext 7=0x1111 and int 7=0x2222 in the same cycle -> collision=1 next cycle; int_ready=0 for that cycle; entry 7 reads 0x1111 then 0x2222.
- Pending starvation: collision, then ext_we high 3 more cycles on other addresses -> int_ready stays 0 for 4 cycles; pending commits in the first cycle with ext_we=0; int_ready returns to 1 the cycle after.
- Bypass: BYPASS=1, write addr 2=0xBEEF while int_rd_addr[1]=2 -> int_rd_data[1]=0xBEEF next cycle. With BYPASS=0 the same stimulus returns the old value.
- Reset mid-run with pending valid -> pending write never appears; full clear repeats; all entries 0.

Source files
------------

// File: rtl/xregf_mp.sv
// Dual-interface register file: host read/write port, versat write port with a
// one-entry collision buffer, N_RD registered versat read ports and a post-reset clear.
module xregf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_RD   = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ext_we,
    input  logic [ADDR_W-1:0]        ext_addr,
    input  logic [DATA_W-1:0]        ext_data_in,
    output logic [DATA_W-1:0]        ext_data_out,
    output logic                     ext_ready,
    input  logic                     int_sel,
    input  logic                     int_we,
    input  logic [ADDR_W-1:0]        int_addr,
    input  logic [DATA_W-1:0]        int_data_in,
    output logic                     int_ready,
    input  logic [N_RD*ADDR_W-1:0]   int_rd_addr,
    output logic [N_RD*DATA_W-1:0]   int_rd_data,
    output logic                     clr_busy,
    output logic                     collision
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              collision_q, collision_d;
    logic [DATA_W-1:0] ext_rd_q;
    logic [DATA_W-1:0] int_rd_q [N_RD];
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run;
    logic              vw;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign run          = (state_q == ST_RUN);
    assign ext_ready    = run;
    assign int_ready    = run & ~pend_vld_q;
    assign clr_busy     = ~run;
    assign collision    = collision_q;
    assign ext_data_out = ext_rd_q;
    assign vw           = int_sel & int_we & int_ready;

    // Registered read with optional forwarding of the write committing this cycle.
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] stored);
        if (BYPASS != 0 && wr_en && wr_addr == a)
            return wr_data;
        return stored;
    endfunction

    // Single commit port: clear sequencer, else host, else pending, else versat.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        collision_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = cnt_q;
        wr_data     = '0;
        if (!run) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}})
                state_d = ST_RUN;
        end else if (ext_we) begin
            wr_en   = 1'b1;
            wr_addr = ext_addr;
            wr_data = ext_data_in;
            if (vw) begin
                pend_vld_d  = 1'b1;
                pend_addr_d = int_addr;
                pend_data_d = int_data_in;
                collision_d = 1'b1;
            end
        end else if (pend_vld_q) begin
            wr_en      = 1'b1;
            wr_addr    = pend_addr_q;
            wr_data    = pend_data_q;
            pend_vld_d = 1'b0;
        end else if (vw) begin
            wr_en   = 1'b1;
            wr_addr = int_addr;
            wr_data = int_data_in;
        end
        // A queued versat write must never land once reset is seen.
        if (rst)
            wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            collision_q <= collision_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_addr_q <= pend_addr_d;
        pend_data_q <= pend_data_d;
        if (wr_en)
            mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ext_rd_q <= '0;
        else
            ext_rd_q <= rd_word(ext_addr, mem_q[ext_addr]);
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = int_rd_addr[k*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (rst)
                int_rd_q[k] <= '0;
            else
                int_rd_q[k] <= rd_word(ra, mem_q[ra]);
        end

        assign int_rd_data[k*DATA_W +: DATA_W] = int_rd_q[k];
    end

endmodule

// File: tb/tb_xregf_mp.sv
// Bench for xregf_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared against a transaction-level model plus a table of hand-derived vectors.
module tb_xregf_mp;

    logic        clk;
    logic        rst;
    logic        ext_we;
    logic [3:0]  ext_addr;
    logic [31:0] ext_din;
    logic        i_sel, i_we;
    logic [3:0]  i_addr;
    logic [31:0] i_din;
    logic [3:0]  rd0, rd1;
    logic [7:0]  rd_addr;

    logic [31:0] o_ext   [2];
    logic [63:0] o_rd    [2];
    logic        o_erdy  [2];
    logic        o_irdy  [2];
    logic        o_busy  [2];
    logic        o_coll  [2];

    int errors = 0;
    int checks = 0;

    assign rd_addr = {rd1, rd0};

    xregf_mp #(.DATA_W(32), .ADDR_W(4), .N_RD(2), .BYPASS(1)) u_b (
        .clk(clk), .rst(rst),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data_in(ext_din),
        .ext_data_out(o_ext[0]), .ext_ready(o_erdy[0]),
        .int_sel(i_sel), .int_we(i_we), .int_addr(i_addr), .int_data_in(i_din),
        .int_ready(o_irdy[0]), .int_rd_addr(rd_addr), .int_rd_data(o_rd[0]),
        .clr_busy(o_busy[0]), .collision(o_coll[0])
    );

    xregf_mp #(.DATA_W(32), .ADDR_W(4), .N_RD(2), .BYPASS(0)) u_n (
        .clk(clk), .rst(rst),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data_in(ext_din),
        .ext_data_out(o_ext[1]), .ext_ready(o_erdy[1]),
        .int_sel(i_sel), .int_we(i_we), .int_addr(i_addr), .int_data_in(i_din),
        .int_ready(o_irdy[1]), .int_rd_addr(rd_addr), .int_rd_data(o_rd[1]),
        .clr_busy(o_busy[1]), .collision(o_coll[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: array contents, cycles of clearing left, queue of deferred versat writes.
    typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
    logic [31:0] m_mem   [16];
    bit          m_known [16];
    int          m_clear_left = 16;
    wr_t         m_pend[$];
    bit          m_coll;
    logic [31:0] m_out   [2][3];
    bit          m_out_k [2][3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit          rdy;
        bit          vw;
        bit          c_en;
        logic [3:0]  c_a;
        logic [31:0] c_d;
        logic [3:0]  ra [3];
        wr_t         p;
        rdy  = (m_clear_left == 0) && (m_pend.size() == 0);
        vw   = i_sel && i_we && rdy;
        ra[0] = ext_addr; ra[1] = rd0; ra[2] = rd1;
        if (rst) begin
            m_clear_left = 16;
            m_pend.delete();
            m_coll = 0;
            for (int d = 0; d < 2; d++)
                for (int j = 0; j < 3; j++) begin
                    m_out[d][j] = '0;
                    m_out_k[d][j] = 1;
                end
            return;
        end
        c_en = 0; c_a = '0; c_d = '0; m_coll = 0;
        if (m_clear_left > 0) begin
            c_en = 1; c_a = 4'(16 - m_clear_left); c_d = '0;
            m_clear_left--;
        end else if (ext_we) begin
            c_en = 1; c_a = ext_addr; c_d = ext_din;
            if (vw) begin
                p.a = i_addr; p.d = i_din;
                m_pend.push_back(p);
                m_coll = 1;
            end
        end else if (m_pend.size() > 0) begin
            p = m_pend.pop_front();
            c_en = 1; c_a = p.a; c_d = p.d;
        end else if (vw) begin
            c_en = 1; c_a = i_addr; c_d = i_din;
        end
        for (int j = 0; j < 3; j++) begin
            m_out[1][j]   = m_mem[ra[j]];
            m_out_k[1][j] = m_known[ra[j]];
            if (c_en && c_a == ra[j]) begin
                m_out[0][j] = c_d; m_out_k[0][j] = 1;
            end else begin
                m_out[0][j] = m_mem[ra[j]]; m_out_k[0][j] = m_known[ra[j]];
            end
        end
        if (c_en) begin
            m_mem[c_a] = c_d;
            m_known[c_a] = 1;
        end
    endtask

    task automatic check_model();
        bit busy;
        busy = (m_clear_left > 0);
        for (int d = 0; d < 2; d++) begin
            if (m_out_k[d][0]) chk($sformatf("m ext_data_out dut%0d", d), o_ext[d], m_out[d][0]);
            if (m_out_k[d][1]) chk($sformatf("m rd_data0 dut%0d", d), o_rd[d][31:0], m_out[d][1]);
            if (m_out_k[d][2]) chk($sformatf("m rd_data1 dut%0d", d), o_rd[d][63:32], m_out[d][2]);
            chk($sformatf("m collision dut%0d", d), 32'(o_coll[d]), 32'(m_coll));
            chk($sformatf("m clr_busy dut%0d", d), 32'(o_busy[d]), 32'(busy));
            chk($sformatf("m ext_ready dut%0d", d), 32'(o_erdy[d]), 32'(!busy));
            chk($sformatf("m int_ready dut%0d", d), 32'(o_irdy[d]), 32'(!busy && m_pend.size() == 0));
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        rst = 0; ext_we = 0; ext_addr = '0; ext_din = '0;
        i_sel = 0; i_we = 0; i_addr = '0; i_din = '0; rd0 = '0; rd1 = '0;
    endtask

    // Pulse reset, count clear cycles (host writes a stray value mid-clear), then read back every entry.
    task automatic reset_and_clear(input string tag);
        int n;
        rst = 1;
        tick();
        idle_inputs();
        n = 0;
        while (o_busy[0] && n < 40) begin
            ext_we   = (n == 2);
            ext_addr = 4'd3;
            ext_din  = 32'hAA;
            tick();
            n++;
        end
        idle_inputs();
        chk({tag, " clear cycles"}, 32'(n), 32'd16);
        chk({tag, " ext_ready after clear"}, 32'(o_erdy[0]), 32'd1);
        chk({tag, " collision after clear"}, 32'(o_coll[0]), 32'd0);
        for (int a = 0; a < 16; a++) begin
            ext_addr = 4'(a); rd0 = 4'(a); rd1 = 4'(15 - a);
            tick();
            chk($sformatf("%s entry %0d ext", tag, a), o_ext[1], 32'd0);
            chk($sformatf("%s entry %0d rd0", tag, a), o_rd[1][31:0], 32'd0);
        end
        idle_inputs();
    endtask

    typedef struct {
        logic        ew;
        logic [3:0]  ea;
        logic [31:0] ed;
        logic        sel;
        logic        iwe;
        logic [3:0]  ia;
        logic [31:0] id;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [31:0] x_ext_b;
        logic [31:0] x_ext_n;
        logic [31:0] x_rd0;
        logic [31:0] x_rd1_b;
        logic [31:0] x_rd1_n;
        logic        x_coll;
        logic        x_irdy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        for (int a = 0; a < 16; a++) begin
            m_mem[a] = '0;
            m_known[a] = 0;
        end
        // Starting from an all-zero file after clear.
        tbl[0]  = '{1'b1, 4'd5,  32'h12345678, 1'b0, 1'b0, 4'd0, 32'h0,    4'd0,  4'd0,
                    32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'd5,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,    4'd5,  4'd5,
                    32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'd7,  32'h1111,     1'b1, 1'b1, 4'd7, 32'h2222, 4'd5,  4'd7,
                    32'h1111, 32'h0, 32'h12345678, 32'h1111, 32'h0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'd7,  32'h0,        1'b1, 1'b1, 4'd7, 32'h2222, 4'd5,  4'd7,
                    32'h2222, 32'h1111, 32'h12345678, 32'h2222, 32'h1111, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'd7,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,    4'd7,  4'd7,
                    32'h2222, 32'h2222, 32'h2222, 32'h2222, 32'h2222, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 4'd8,  32'h8888,     1'b1, 1'b1, 4'd9, 32'h9999, 4'd7,  4'd9,
                    32'h8888, 32'h0, 32'h2222, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'd10, 32'hAAAA,     1'b1, 1'b1, 4'd9, 32'h9999, 4'd8,  4'd9,
                    32'hAAAA, 32'h0, 32'h8888, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'd11, 32'hBBBB,     1'b1, 1'b1, 4'd9, 32'h9999, 4'd10, 4'd9,
                    32'hBBBB, 32'h0, 32'hAAAA, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'd12, 32'hCCCC,     1'b1, 1'b1, 4'd9, 32'h9999, 4'd11, 4'd9,
                    32'hCCCC, 32'h0, 32'hBBBB, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'd12, 32'h0,        1'b1, 1'b1, 4'd9, 32'h9999, 4'd12, 4'd9,
                    32'hCCCC, 32'hCCCC, 32'hCCCC, 32'h9999, 32'h0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'd9,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,    4'd9,  4'd9,
                    32'h9999, 32'h9999, 32'h9999, 32'h9999, 32'h9999, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 4'd9,  32'h0,        1'b1, 1'b1, 4'd2, 32'hBEEF, 4'd9,  4'd2,
                    32'h9999, 32'h9999, 32'h9999, 32'hBEEF, 32'h0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 4'd2,  32'h0,        1'b0, 1'b0, 4'd0, 32'h0,    4'd2,  4'd2,
                    32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF, 1'b0, 1'b1};

        idle_inputs();
        reset_and_clear("por");

        for (int i = 0; i < 13; i++) begin
            ext_we = tbl[i].ew; ext_addr = tbl[i].ea; ext_din = tbl[i].ed;
            i_sel = tbl[i].sel; i_we = tbl[i].iwe; i_addr = tbl[i].ia; i_din = tbl[i].id;
            rd0 = tbl[i].r0; rd1 = tbl[i].r1;
            tick();
            chk($sformatf("vec%0d ext byp", i), o_ext[0], tbl[i].x_ext_b);
            chk($sformatf("vec%0d ext nobyp", i), o_ext[1], tbl[i].x_ext_n);
            chk($sformatf("vec%0d rd0 byp", i), o_rd[0][31:0], tbl[i].x_rd0);
            chk($sformatf("vec%0d rd0 nobyp", i), o_rd[1][31:0], tbl[i].x_rd0);
            chk($sformatf("vec%0d rd1 byp", i), o_rd[0][63:32], tbl[i].x_rd1_b);
            chk($sformatf("vec%0d rd1 nobyp", i), o_rd[1][63:32], tbl[i].x_rd1_n);
            chk($sformatf("vec%0d collision", i), 32'(o_coll[0]), 32'(tbl[i].x_coll));
            chk($sformatf("vec%0d int_ready", i), 32'(o_irdy[0]), 32'(tbl[i].x_irdy));
        end
        idle_inputs();

        // Reset while a collided versat write is still queued.
        ext_we = 1; ext_addr = 4'd3; ext_din = 32'h3333;
        i_sel = 1; i_we = 1; i_addr = 4'd4; i_din = 32'h4444;
        tick();
        chk("midrst collision", 32'(o_coll[0]), 32'd1);
        chk("midrst int_ready", 32'(o_irdy[0]), 32'd0);
        ext_we = 0;
        reset_and_clear("midrst");

        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 149) == 0);
            ext_we   = ($urandom_range(0, 2) == 0);
            ext_addr = 4'($urandom_range(0, 15));
            ext_din  = $urandom;
            i_sel    = ($urandom_range(0, 3) != 0);
            i_we     = ($urandom_range(0, 1) == 0);
            i_addr   = 4'($urandom_range(0, 15));
            i_din    = $urandom;
            rd0      = 4'($urandom_range(0, 15));
            rd1      = ($urandom_range(0, 1) == 0) ? ext_addr : 4'($urandom_range(0, 15));
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
